// File: rtl/conv_activation_streamer.sv
// Activation stream producer. It reads an S x S feature map from a BRAM with one cycle of
// read latency and emits it row-major as a (S+2P) x (S+2P) zero-padded valid/ready stream.
// Each issued slot passes through a one-stage in-flight register and then a two-entry FIFO.
// A credit check stops a slot from issuing when it would have no FIFO entry to land in.
module conv_activation_streamer #(
  parameter int unsigned N             = 16,
  parameter int unsigned MaxMatrixSize = 16383,
  parameter int unsigned PadBits       = 4,
  parameter int unsigned AddrBits      = 28
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [13:0]         matrix_size_i,
  input  logic [PadBits-1:0]  padding_i,
  input  logic [AddrBits-1:0] base_addr_i,
  output logic                mem_rd_en_o,
  output logic [AddrBits-1:0] mem_addr_o,
  input  logic [N-1:0]        mem_data_i,
  output logic [N-1:0]        data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o
);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e               state_q, state_d;
  logic [13:0]          s_q, s_d;
  logic [PadBits-1:0]   p_q, p_d;
  logic [14:0]          ps_q, ps_d;
  logic [13:0]          r_q, r_d;
  logic [13:0]          c_q, c_d;
  logic [AddrBits-1:0]  addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_pad_q, inflight_pad_d;
  logic [N-1:0]         fifo_q [2];
  logic [N-1:0]         fifo_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;

  // Slot classification and credit signals
  logic        pop, push;
  logic [2:0]  occ;
  logic        can_issue;
  logic [14:0] r_ext, c_ext, p_ext, s_ext, p_plus_s;
  logic        row_pad, col_pad, slot_pad;
  logic        last_col, last_row;
  logic [14:0] ps_cfg;
  logic [N-1:0] push_data;

  // Decode the current slot, the credit state and the padded size of a new request
  always_comb begin
    pop       = (count_q != 2'd0) && ready_i;
    push      = inflight_q;
    // Entries already owed to the FIFO after this cycle's pop
    occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    can_issue = (state_q == StStream) && (occ < 3'd2);
    r_ext     = {1'b0, r_q};
    c_ext     = {1'b0, c_q};
    p_ext     = 15'(p_q);
    s_ext     = {1'b0, s_q};
    p_plus_s  = p_ext + s_ext;
    row_pad   = (r_ext < p_ext) || (r_ext >= p_plus_s);
    col_pad   = (c_ext < p_ext) || (c_ext >= p_plus_s);
    slot_pad  = row_pad || col_pad;
    last_col  = (c_ext == ps_q - 15'd1);
    last_row  = (r_ext == ps_q - 15'd1);
    ps_cfg    = {1'b0, matrix_size_i} + 15'({padding_i, 1'b0});
    push_data = inflight_pad_q ? '0 : mem_data_i;
  end

  // Next-state logic for the FSM, slot counters, in-flight stage and output FIFO
  always_comb begin
    state_d        = state_q;
    s_d            = s_q;
    p_d            = p_q;
    ps_d           = ps_q;
    r_d            = r_q;
    c_d            = c_q;
    addr_d         = addr_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fifo_d         = fifo_q;
    done_d         = 1'b0;
    cfg_err_d      = cfg_err_q;
    inflight_d     = can_issue;
    inflight_pad_d = can_issue ? slot_pad : inflight_pad_q;

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      StIdle: begin
        if (start_i) begin
          if ({17'b0, ps_cfg} > MaxMatrixSize) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d = 1'b0;
            s_d       = matrix_size_i;
            p_d       = padding_i;
            ps_d      = ps_cfg;
            addr_d    = base_addr_i;
            r_d       = '0;
            c_d       = '0;
            if (matrix_size_i == 14'd0) begin
              done_d = 1'b1;
            end else begin
              state_d = StStream;
            end
          end
        end
      end
      StStream: begin
        if (can_issue) begin
          if (!slot_pad) begin
            addr_d = addr_q + 1'b1;
          end
          if (last_col) begin
            c_d = '0;
            r_d = r_q + 14'd1;
            if (last_row) begin
              state_d = StDrain;
            end
          end else begin
            c_d = c_q + 14'd1;
          end
        end
      end
      StDrain: begin
        // Leave as the final element is popped so done_o lines up with the last beat
        if (!inflight_q && (count_d == 2'd0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= StIdle;
      s_q            <= '0;
      p_q            <= '0;
      ps_q           <= '0;
      r_q            <= '0;
      c_q            <= '0;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_pad_q <= 1'b0;
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      p_q            <= p_d;
      ps_q           <= ps_d;
      r_q            <= r_d;
      c_q            <= c_d;
      addr_q         <= addr_d;
      inflight_q     <= inflight_d;
      inflight_pad_q <= inflight_pad_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign mem_rd_en_o = can_issue && !slot_pad;
  assign mem_addr_o  = addr_q;
  assign data_o      = fifo_q[rd_ptr_q];
  assign valid_o     = (count_q != 2'd0);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_conv_activation_streamer.sv
// Randomised bench for conv_activation_streamer. The expected stream is computed from the
// padding rule, and the BRAM returns a value derived from the address read.
module tb_conv_activation_streamer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [13:0] matrix_size_i = '0;
  logic [3:0]  padding_i = '0;
  logic [27:0] base_addr_i = '0;
  logic        mem_rd_en_o;
  logic [27:0] mem_addr_o;
  logic [15:0] mem_data_i = '0;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;

  conv_activation_streamer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .matrix_size_i (matrix_size_i),
    .padding_i     (padding_i),
    .base_addr_i   (base_addr_i),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] mem_xor = '0;
  bit ready_rand = 1'b0;

  logic [15:0] got_q[$];
  logic [27:0] rd_q[$];
  logic [15:0] exp_q[$];
  logic [27:0] exp_rd_q[$];
  int first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc, done_cnt, valid_cnt;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [27:0] a);
    logic [27:0] d;
    d = a - 28'h0FF;
    return d[15:0] ^ mem_xor;
  endfunction

  // BRAM model: one cycle of read latency
  always @(posedge clk_i) begin
    if (mem_rd_en_o) mem_data_i <= mem_val(mem_addr_o);
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  // Consumer ready, changed just after each edge
  always @(posedge clk_i) begin
    #1;
    ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor at the falling edge, when every signal is settled
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_o) valid_cnt++;
      if (prev_stall) begin
        check_val("stall_valid", int'(valid_o), 1);
        check_val("stall_data", int'(data_o), int'(prev_data));
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      if (valid_o && ready_i) begin
        got_q.push_back(data_o);
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      if (mem_rd_en_o) rd_q.push_back(mem_addr_o);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    rd_q.delete();
    first_valid_cyc = -1;
    first_beat_cyc  = -1;
    last_beat_cyc   = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    valid_cnt       = 0;
  endtask

  // Expected padded stream and read addresses
  task automatic build_model(input int s, input int p, input logic [27:0] base);
    int ps;
    int k;
    exp_q.delete();
    exp_rd_q.delete();
    ps = s + 2 * p;
    k  = 0;
    if (s == 0) return;
    for (int r = 0; r < ps; r++) begin
      for (int c = 0; c < ps; c++) begin
        if (r < p || r >= p + s || c < p || c >= p + s) begin
          exp_q.push_back(16'h0);
        end else begin
          exp_q.push_back(mem_val(base + 28'(k)));
          exp_rd_q.push_back(base + 28'(k));
          k++;
        end
      end
    end
  endtask

  task automatic run_cfg(input string name, input int s, input int p, input logic [27:0] base,
                         input bit rnd, input bit dbl_start);
    int ps;
    int k0;
    int bound;
    ps = s + 2 * p;
    build_model(s, p, base);
    ready_rand = rnd;
    @(posedge clk_i); #2;
    clear_mon();
    matrix_size_i = 14'(s);
    padding_i     = 4'(p);
    base_addr_i   = base;
    start_i       = 1'b1;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    k0 = cyc;
    bound = 4 * ps * ps + 40;
    for (int i = 0; i < bound && done_cnt == 0; i++) begin
      if (dbl_start && i == 4) begin
        matrix_size_i = 14'd2;
        padding_i     = 4'd0;
        start_i       = 1'b1;
      end
      if (i == 6) start_i = 1'b0;
      @(posedge clk_i); #2;
    end
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    check_val({name, " done_seen"}, done_cnt, 1);
    check_val({name, " beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val($sformatf("%s beat%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
    check_val({name, " reads"}, rd_q.size(), exp_rd_q.size());
    for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++)
      check_val($sformatf("%s addr%0d", name, i), int'(rd_q[i]), int'(exp_rd_q[i]));
    if (s == 0) begin
      check_val({name, " done_at"}, done_cyc, k0);
      check_val({name, " valid_cnt"}, valid_cnt, 0);
    end else begin
      check_val({name, " first_valid"}, first_valid_cyc, k0 + 2);
      check_val({name, " done_after_last"}, done_cyc, last_beat_cyc + 1);
      if (!rnd) check_val({name, " no_bubble"}, last_beat_cyc - first_beat_cyc, ps * ps - 1);
    end
    check_val({name, " busy_end"}, int'(busy_o), 0);
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk_i);
    #2;
    check_val("rst valid", int'(valid_o), 0);
    check_val("rst busy", int'(busy_o), 0);
    check_val("rst done", int'(done_o), 0);
    check_val("rst cfg_err", int'(cfg_err_o), 0);
    check_val("rst rd_en", int'(mem_rd_en_o), 0);
    rst_i = 1'b1;

    mem_xor = 16'h0;
    run_cfg("t1", 3, 1, 28'h100, 1'b0, 1'b0);
    run_cfg("t2", 3, 1, 28'h100, 1'b1, 1'b0);
    mem_xor = 16'(($urandom));
    run_cfg("t3", 4, 0, 28'(($urandom)), 1'b0, 1'b0);

    // Oversized request is rejected
    @(posedge clk_i); #2;
    clear_mon();
    matrix_size_i = 14'd16380;
    padding_i     = 4'd2;
    start_i       = 1'b1;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    check_val("t4 cfg_err", int'(cfg_err_o), 1);
    check_val("t4 busy", int'(busy_o), 0);
    check_val("t4 reads", rd_q.size(), 0);
    check_val("t4 valid", valid_cnt, 0);
    run_cfg("t4b", 2, 0, 28'h40, 1'b0, 1'b0);
    check_val("t4b cfg_err", int'(cfg_err_o), 0);

    run_cfg("t5", 0, 3, 28'h200, 1'b0, 1'b0);
    mem_xor = 16'h0;
    run_cfg("t5b", 3, 1, 28'h100, 1'b0, 1'b1);

    // Address wrap and random configurations
    mem_xor = 16'(($urandom));
    run_cfg("wrap", 3, 2, 28'hFFFFFFE, 1'b1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      mem_xor = 16'(($urandom));
      run_cfg($sformatf("rnd%0d", t), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
              28'(($urandom)), 1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of a run
    mem_xor = 16'h0;
    ready_rand = 1'b0;
    @(posedge clk_i); #2;
    clear_mon();
    matrix_size_i = 14'd3;
    padding_i     = 4'd1;
    base_addr_i   = 28'h100;
    start_i       = 1'b1;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    for (int i = 0; i < 100 && got_q.size() < 10; i++) @(negedge clk_i);
    check_val("t6 reach_beat10", int'(got_q.size() >= 10), 1);
    #2;
    rst_i = 1'b0;
    #1;
    check_val("t6 valid", int'(valid_o), 0);
    check_val("t6 busy", int'(busy_o), 0);
    check_val("t6 done", int'(done_o), 0);
    repeat (2) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    check_val("t6 no_done", done_cnt, 0);
    run_cfg("t6b", 3, 1, 28'h100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
